// File: rtl/bundle_cmd_scheduler.sv
// bundle_cmd_scheduler
//   Command FIFO and sequencer in front of BundleKernelMapper. Host commands
//   (hva/hvb/hvc/len/mode/tag) are queued and issued one at a time, in order,
//   using the mapper's valid-held-until-done handshake. Every command yields
//   exactly one response pulse carrying its tag and an error flag.
//
//   Optional macro SCHED_TIMEOUT_EN: adds a watchdog that aborts an in-flight
//   command (error response) if k_done has not arrived within TIMEOUT_CLKS
//   clocks of k_valid rising. Without it RUN waits for k_done indefinitely.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready     host command handshake
//   cmd_hva/hvb/hvc/len     operand/result base addresses and length
//   cmd_mode, cmd_tag       bundling mode and user tag
//   k_valid, k_vec_length,
//   k_hva/hvb/hvc, k_mode   request to the mapper (held while k_valid=1)
//   k_done                  completion from the mapper
//   rsp_valid/tag/err       one-cycle completion pulse
//   busy                    sequencer active or commands queued
//   fifo_count              queued commands (in-flight command excluded)
module bundle_cmd_scheduler #(
    parameter int HV_ADDRESS_WIDTH       = 5,
    parameter int MAX_HYPERVECTOR_LENGTH = 4,
    parameter int CMD_DEPTH              = 4,
    parameter int TAG_WIDTH              = 4,
    parameter int TIMEOUT_CLKS           = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [HV_ADDRESS_WIDTH-1:0]   cmd_hva,
    input  logic [HV_ADDRESS_WIDTH-1:0]   cmd_hvb,
    input  logic [HV_ADDRESS_WIDTH-1:0]   cmd_hvc,
    input  logic [HV_ADDRESS_WIDTH-1:0]   cmd_len,
    input  logic                          cmd_mode,
    input  logic [TAG_WIDTH-1:0]          cmd_tag,
    output logic                          k_valid,
    output logic [HV_ADDRESS_WIDTH-1:0]   k_vec_length,
    output logic [HV_ADDRESS_WIDTH-1:0]   k_hva,
    output logic [HV_ADDRESS_WIDTH-1:0]   k_hvb,
    output logic [HV_ADDRESS_WIDTH-1:0]   k_hvc,
    output logic                          k_mode,
    input  logic                          k_done,
    output logic                          rsp_valid,
    output logic [TAG_WIDTH-1:0]          rsp_tag,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [$clog2(CMD_DEPTH):0]    fifo_count
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [HV_ADDRESS_WIDTH-1:0] MAX_LEN = HV_ADDRESS_WIDTH'(MAX_HYPERVECTOR_LENGTH);

    typedef struct packed {
        logic [HV_ADDRESS_WIDTH-1:0] hva;
        logic [HV_ADDRESS_WIDTH-1:0] hvb;
        logic [HV_ADDRESS_WIDTH-1:0] hvc;
        logic [HV_ADDRESS_WIDTH-1:0] len;
        logic                        mode;
        logic [TAG_WIDTH-1:0]        tag;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

    cmd_t                  fifo_mem_q [CMD_DEPTH];
    cmd_t                  cmd_in;
    cmd_t                  head;
    logic                  head_legal;
    logic                  push;
    logic                  pop;

    logic [PTR_W-1:0]      wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]      count_q,   count_d;
    state_t                state_q,   state_d;
    cmd_t                  kcmd_q,    kcmd_d;    // in-flight command (fields + tag)
    logic                  k_valid_q, k_valid_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
    logic                  rsp_err_q, rsp_err_d;
`ifdef SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    logic [TMO_W-1:0]      tmo_q, tmo_d;
`endif

    assign cmd_in     = '{hva: cmd_hva, hvb: cmd_hvb, hvc: cmd_hvc, len: cmd_len,
                          mode: cmd_mode, tag: cmd_tag};
    assign cmd_ready  = (count_q < CNT_W'(CMD_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign head       = fifo_mem_q[rd_ptr_q];
    assign head_legal = (head.len != '0) && (head.len <= MAX_LEN);

    always_comb begin
        pop         = 1'b0;
        state_d     = state_q;
        kcmd_d      = kcmd_q;
        k_valid_d   = k_valid_q;
        rsp_valid_d = 1'b0;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
`ifdef SCHED_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                // The head is only visible once its push edge has passed, so
                // there is no same-cycle bypass from cmd_* to k_*.
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        kcmd_d    = head;
                        k_valid_d = 1'b1;
                        state_d   = S_RUN;
`ifdef SCHED_TIMEOUT_EN
                        tmo_d     = '0;
`endif
                    end else begin
                        // Rejected without touching the mapper interface.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_tag_d   = head.tag;
                    end
                end
            end
            S_RUN: begin
                if (k_done) begin
                    k_valid_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_tag_d   = kcmd_q.tag;
                    rsp_err_d   = 1'b0;
                    state_d     = S_GAP;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
                    k_valid_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_tag_d   = kcmd_q.tag;
                    rsp_err_d   = 1'b1;
                    state_d     = S_GAP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            // One cycle with k_valid low so the mapper sees a fresh request.
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pointers wrap naturally: CMD_DEPTH is a power of two.
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            kcmd_q      <= '0;
            k_valid_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            kcmd_q      <= kcmd_d;
            k_valid_q   <= k_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
`ifdef SCHED_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    // Storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= cmd_in;
    end

    assign k_valid      = k_valid_q;
    assign k_hva        = kcmd_q.hva;
    assign k_hvb        = kcmd_q.hvb;
    assign k_hvc        = kcmd_q.hvc;
    assign k_vec_length = kcmd_q.len;
    assign k_mode       = kcmd_q.mode;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_tag      = rsp_tag_q;
    assign rsp_err      = rsp_err_q;
    assign fifo_count   = count_q;
    assign busy         = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_bundle_cmd_scheduler.sv
// Self-checking bench for bundle_cmd_scheduler: directed scenarios plus a
// randomized command stream, checked against a queue-based reference model.
module tb_bundle_cmd_scheduler;
    localparam int AW = 5, TW = 4, DEPTH = 4, MAXL = 4, TMO = 16;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [AW-1:0] cmd_hva = '0, cmd_hvb = '0, cmd_hvc = '0, cmd_len = '0;
    logic          cmd_mode = 1'b0;
    logic [TW-1:0] cmd_tag = '0;
    logic          k_valid, k_mode, k_done = 1'b0;
    logic [AW-1:0] k_vec_length, k_hva, k_hvb, k_hvc;
    logic          rsp_valid, rsp_err, busy;
    logic [TW-1:0] rsp_tag;
    logic [$clog2(DEPTH):0] fifo_count;

    bundle_cmd_scheduler #(.HV_ADDRESS_WIDTH(AW), .MAX_HYPERVECTOR_LENGTH(MAXL),
        .CMD_DEPTH(DEPTH), .TAG_WIDTH(TW), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_hva(cmd_hva), .cmd_hvb(cmd_hvb), .cmd_hvc(cmd_hvc), .cmd_len(cmd_len),
        .cmd_mode(cmd_mode), .cmd_tag(cmd_tag), .k_valid(k_valid),
        .k_vec_length(k_vec_length), .k_hva(k_hva), .k_hvb(k_hvb), .k_hvc(k_hvc),
        .k_mode(k_mode), .k_done(k_done), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
        .rsp_err(rsp_err), .busy(busy), .fifo_count(fifo_count));

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] hva, hvb, hvc, len; logic mode; logic [TW-1:0] tag; } cmd_s;
    typedef struct { logic [TW-1:0] tag; logic err; } rsp_s;

    cmd_s issue_q[$];   // legal commands in the order the mapper must see them
    rsp_s rsp_q[$];     // every accepted command's expected response, in order
    int   compared = 0, mismatched = 0;
    int   n_rsp = 0, n_issue = 0;
    bit   tmo_expect = 1'b0;
    bit   mapper_en = 1'b0, rand_delay = 1'b0;
    int   mapper_delay = 3, mapper_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mapper model: raises done mapper_delay cycles after seeing valid.
    always @(negedge clk) begin
        if (mapper_en) begin
            if (k_valid) begin
                mapper_cnt++;
                k_done = (mapper_cnt == mapper_delay);
            end else begin
                mapper_cnt = 0;
                k_done = 1'b0;
                if (rand_delay) mapper_delay = $urandom_range(1, 6);
            end
        end
    end

    // Monitor: issue order/fields, field stability, response order/contents.
    logic prev_kv = 1'b0, prev_rsp = 1'b0, prev_err = 1'b0;
    cmd_s cur;
    always @(negedge clk) begin
        if (k_valid && !prev_kv) begin
            n_issue++;
            chk("issue_expected", 32'(issue_q.size() != 0), 1);
            if (issue_q.size() != 0) begin
                cur = issue_q.pop_front();
                chk("issue_fields", {k_hva, k_hvb, k_hvc, k_vec_length, k_mode},
                    {cur.hva, cur.hvb, cur.hvc, cur.len, cur.mode});
            end
        end else if (k_valid) begin
            chk("k_stable", {k_hva, k_hvb, k_hvc, k_vec_length, k_mode},
                {cur.hva, cur.hvb, cur.hvc, cur.len, cur.mode});
        end
        if (rsp_valid) begin
            rsp_s e;
            n_rsp++;
            chk("rsp_expected", 32'(rsp_q.size() != 0), 1);
            if (rsp_q.size() != 0) begin
                e = rsp_q.pop_front();
                chk("rsp_tag_err", {rsp_tag, rsp_err}, {e.tag, e.err});
            end
            if (prev_rsp) chk("rsp_b2b_only_illegal", {prev_err, rsp_err}, 2'b11);
            chk("kv_low_at_rsp", k_valid, 0);
        end
        prev_kv  = k_valid;
        prev_rsp = rsp_valid;
        prev_err = rsp_err;
    end

    // Starts and ends just after a negedge; back-to-back calls keep cmd_valid high.
    task automatic send(input logic [AW-1:0] hva, hvb, hvc, len, input logic mode,
                        input logic [TW-1:0] tag, input int budget);
        bit acc = 1'b0;
        int n = 0;
        cmd_hva = hva; cmd_hvb = hvb; cmd_hvc = hvc; cmd_len = len;
        cmd_mode = mode; cmd_tag = tag; cmd_valid = 1'b1;
        while (!acc && n < budget) begin
            #1 acc = cmd_ready;
            @(posedge clk);
            if (acc) begin
                bit ill = (len == 0) || (len > MAXL);
                rsp_q.push_back('{tag: tag, err: ill | tmo_expect});
                if (!ill) issue_q.push_back('{hva: hva, hvb: hvb, hvc: hvc, len: len,
                                               mode: mode, tag: tag});
            end
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        chk("accept_in_budget", 32'(acc), 1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy !== 1'b0 || rsp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_busy", busy, 0);
        chk("idle_rsp_drained", rsp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base_rsp, base_issue, cnt;

        // Reset state.
        tick(2);
        reset_n = 1'b1;
        chk("rst_k_valid", k_valid, 0);
        chk("rst_k_fields", {k_hva, k_hvb, k_hvc, k_vec_length, k_mode}, 0);
        chk("rst_rsp", {rsp_valid, rsp_tag, rsp_err}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", cmd_ready, 1);

        // Single command, done 10 cycles after valid.
        mapper_delay = 10; mapper_en = 1'b1;
        base_rsp = n_rsp;
        send(5'd0, 5'd12, 5'd16, 5'd4, 1'b1, 4'd3, 4);
        chk("t1_kv_low_after_accept", k_valid, 0);
        chk("t1_count_one", fifo_count, 1);
        tick(1);
        chk("t1_kv_rise", k_valid, 1);
        chk("t1_fields", {k_hva, k_hvb, k_hvc, k_vec_length, k_mode},
            {5'd0, 5'd12, 5'd16, 5'd4, 1'b1});
        wait_idle(50);
        chk("t1_one_rsp", n_rsp - base_rsp, 1);

        // Stalled mapper: fill the FIFO, then release.
        mapper_en = 1'b0; k_done = 1'b0; mapper_cnt = 0;
        base_rsp = n_rsp;
        for (int t = 0; t < 5; t++) send(5'(t), 5'(t + 8), 5'(t + 16), 5'd2, 1'(t), 4'(t), 4);
        chk("stall_ready_low", cmd_ready, 0);
        chk("stall_count_full", fifo_count, 4);
        chk("stall_kv_high", k_valid, 1);
        mapper_delay = 4; mapper_en = 1'b1;
        send(5'd5, 5'd13, 5'd21, 5'd3, 1'b0, 4'd5, 100);
        wait_idle(200);
        chk("stall_six_rsp", n_rsp - base_rsp, 6);

        // Illegal lengths, back to back.
        base_rsp = n_rsp; base_issue = n_issue;
        send(5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 4'd1, 4);
        send(5'd1, 5'd2, 5'd3, 5'd5, 1'b1, 4'd2, 4);
        wait_idle(20);
        chk("ill_no_issue", n_issue - base_issue, 0);
        chk("ill_two_rsp", n_rsp - base_rsp, 2);

        // Reset while running with two queued.
        mapper_en = 1'b0; k_done = 1'b0; mapper_cnt = 0;
        send(5'd4, 5'd5, 5'd6, 5'd1, 1'b0, 4'd7, 4);
        send(5'd4, 5'd5, 5'd6, 5'd2, 1'b0, 4'd8, 4);
        send(5'd4, 5'd5, 5'd6, 5'd3, 1'b1, 4'd9, 4);
        chk("mid_count_two", fifo_count, 2);
        chk("mid_kv_high", k_valid, 1);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        chk("mid_rst_kv", k_valid, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy", busy, 0);
        issue_q.delete(); rsp_q.delete();
        base_rsp = n_rsp;
        mapper_en = 1'b1;
        tick(20);
        chk("mid_rst_no_rsp", n_rsp - base_rsp, 0);

        // Done while idle is ignored; completion needs a fresh done.
        mapper_en = 1'b0; mapper_cnt = 0;
        base_rsp = n_rsp;
        k_done = 1'b1; tick(3); k_done = 1'b0;
        chk("idle_done_no_rsp", n_rsp - base_rsp, 0);
        chk("idle_done_busy", busy, 0);
        send(5'd9, 5'd10, 5'd11, 5'd4, 1'b1, 4'd10, 4);
        tick(6);
        chk("idle_done_still_run", k_valid, 1);
        chk("idle_done_no_early_rsp", n_rsp - base_rsp, 0);
        k_done = 1'b1; tick(1); k_done = 1'b0;
        chk("idle_done_rsp", {rsp_valid, rsp_tag, rsp_err, k_valid}, {1'b1, 4'd10, 1'b0, 1'b0});
        wait_idle(10);

        // Mapper never answers.
`ifdef SCHED_TIMEOUT_EN
        tmo_expect = 1'b1;
`endif
        send(5'd7, 5'd8, 5'd9, 5'd3, 1'b0, 4'd11, 4);
        tmo_expect = 1'b0;
        cnt = 0;
        while (!k_valid && cnt < 10) begin tick(1); cnt++; end
        chk("tmo_kv_rise", k_valid, 1);
        cnt = 0;
        while (k_valid && cnt < 100) begin cnt++; tick(1); end
`ifdef SCHED_TIMEOUT_EN
        chk("tmo_high_cycles", cnt, TMO);
        chk("tmo_rsp", {rsp_valid, rsp_tag, rsp_err}, {1'b1, 4'd11, 1'b1});
`else
        chk("no_tmo_high_cycles", cnt, 100);
        mapper_cnt = 0; mapper_delay = 2; mapper_en = 1'b1;
`endif
        wait_idle(20);

        // Randomized stream against the queue model.
        mapper_cnt = 0; rand_delay = 1'b1; mapper_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom_range(0, 6)),
                 1'($urandom), 4'($urandom), 200);
            tick($urandom_range(0, 2));
        end
        wait_idle(2000);
        chk("rand_issue_drained", issue_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bundle_cmd_scheduler.md
Name: bundle_cmd_scheduler

Overview:
Command queue and sequencer in front of BundleKernelMapper. It buffers bundle commands from a host or higher-level controller: operand addresses hva/hvb, destination hvc, length, mode and a tag. It issues the commands one at a time, in order, using the mapper's valid-held-until-done handshake. Each command produces one response (tag plus error flag), so upstream logic can chain multi-step hypervector bundling without tracking mapper timing.

Parameters:
HV_ADDRESS_WIDTH, 5, width of hypervector addresses and length
MAX_HYPERVECTOR_LENGTH, 4, largest legal cmd_len
CMD_DEPTH, 4, command FIFO depth; power of two, >=2
TAG_WIDTH, 4, width of the command tag
TIMEOUT_CLKS, 64, watchdog limit in clocks (used only with the optional feature)

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept a command
cmd_hva  in  HV_ADDRESS_WIDTH  operand A base address
cmd_hvb  in  HV_ADDRESS_WIDTH  operand B base address
cmd_hvc  in  HV_ADDRESS_WIDTH  result base address
cmd_len  in  HV_ADDRESS_WIDTH  hypervector length in words
cmd_mode  in  1  bundling mode (0 = A&B, 1 = A->B)
cmd_tag  in  TAG_WIDTH  user tag returned in the response
k_valid  out  1  to mapper valid
k_vec_length  out  HV_ADDRESS_WIDTH  to mapper vec_length
k_hva / k_hvb / k_hvc  out  HV_ADDRESS_WIDTH each  to mapper hva/hvb/hvc
k_mode  out  1  to mapper mode
k_done  in  1  from mapper done
rsp_valid  out  1  one-cycle completion pulse
rsp_tag  out  TAG_WIDTH  tag of the completed command
rsp_err  out  1  command rejected or aborted
busy  out  1  FSM not IDLE or FIFO non-empty
fifo_count  out  clog2(CMD_DEPTH)+1  queued commands (excludes the in-flight command)

Behaviour:
- Reset (reset_n=0 at a rising edge): FIFO emptied, FSM to IDLE.
  - Outputs after reset: k_valid=0, all k_* fields=0, rsp_valid=0, rsp_tag=0, rsp_err=0, busy=0, fifo_count=0.
  - cmd_ready is 1 from the first clock after reset.
  - Reset mid-operation drops the in-flight and all queued commands; no response is emitted for them.
- FIFO:
  - cmd_ready = (fifo_count < CMD_DEPTH), derived combinationally from registered count.
  - Push when cmd_valid & cmd_ready. No bypass: a pushed entry is poppable from the next cycle.
  - Push and pop in the same cycle: count unchanged. Pointers wrap modulo CMD_DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head.
    - Legal (1 <= cmd_len <= MAX_HYPERVECTOR_LENGTH): register fields into k_*, set k_valid=1, go to RUN.
    - Illegal: k_* untouched, k_valid stays 0, rsp_valid=1 with rsp_err=1 and rsp_tag=entry tag for one cycle, stay in IDLE.
  - RUN: k_valid=1 and k_* held stable. On an edge sampling k_done=1: k_valid<=0, rsp_valid<=1, rsp_tag<=tag, rsp_err<=0, go to GAP.
  - GAP: k_valid=0 for exactly one cycle so the mapper sees valid low, then IDLE. No pop in GAP.
- Latency: command accepted on edge t into an empty FIFO with FSM IDLE → k_valid high after edge t+1. k_done sampled on edge d → rsp_valid high for the cycle after d. Next k_valid rises no earlier than edge d+2.
- k_done is ignored in IDLE and GAP.
- rsp_valid is never high in two consecutive cycles except for back-to-back illegal commands.
- Commands complete strictly in FIFO order.

Optional Feature:
SCHED_TIMEOUT_EN
- Defined: a counter runs in RUN. If k_done is not seen within TIMEOUT_CLKS cycles of k_valid rising, the command is aborted: k_valid<=0, rsp_valid=1 with rsp_err=1 and the in-flight tag, FSM goes to GAP. The counter clears on entry to RUN.
- Not defined: no counter is synthesised; RUN waits for k_done indefinitely.

Test Plan:
- Single command hva=0, hvb=12, hvc=16, len=4, mode=1, tag=3; mapper model asserts done 10 cycles after valid → k_valid high one edge after accept with fields exactly as given; k_valid low the edge after done; one rsp_valid pulse with tag=3, err=0; busy returns to 0.
- Mapper stalled, 6 commands with tags 0..5 offered back-to-back, CMD_DEPTH=4 → first enters RUN, next 4 queue; cmd_ready=0 with fifo_count=4; tag 5 accepted only after a pop; responses arrive in order 0..5; every pair of consecutive k_valid pulses is separated by at least one low cycle.
- Commands with len=0 (tag 1) and len=5 (tag 2) → rsp_err=1 with tags 1 and 2; k_valid never rises.
- reset_n=0 for one edge while in RUN with 2 queued → next cycle k_valid=0, fifo_count=0, busy=0; no rsp_valid ever emitted for those tags.
- k_done pulsed while IDLE, then a legal command issued → no spurious response; the command completes only on the following done.
- With SCHED_TIMEOUT_EN and TIMEOUT_CLKS=16, mapper never asserts done → k_valid drops 16 cycles after rising, rsp_err=1 with the in-flight tag; without the macro, k_valid stays high through 100 cycles.
